// File: rtl/prio_arbiter_pkg.sv
// Shared types and constants for the priority / round-robin grant arbiter.
package prio_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// Combinational winner selection: highest set index (fixed) or first set bit
// searching downward from ptr with wrap (round-robin).
module rr_pick
  import prio_arbiter_pkg::*;
#(
  parameter int N    = 8,
  parameter int IDXW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] ptr,
  input  logic            rr_en,
  output logic [IDXW-1:0] win_idx,
  output logic            win_any
);

  // Each requester gets a search distance; the smallest distance with a set
  // request wins. Fixed mode is just distance measured from the top index.
  always_comb begin
    int best_d;
    int d;
    win_any = |req;
    win_idx = '0;
    best_d  = N;
    d       = 0;
    for (int i = 0; i < N; i++) begin
      if (rr_en == MODE_RR) begin
        d = int'(ptr) - i;
        if (d < 0) d = d + N;
      end else begin
        d = N - 1 - i;
      end
      if (req[i] && (d < best_d)) begin
        best_d  = d;
        win_idx = IDXW'(i);
      end
    end
  end

endmodule

// File: rtl/prio_arbiter.sv
// Request arbiter with registered grant, valid/ready handshake and a
// round-robin pointer that advances on every accepted grant.
module prio_arbiter
  import prio_arbiter_pkg::*;
#(
  parameter int N    = 8,
  parameter int IDXW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            rr_en,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [IDXW-1:0] grant_idx,
  output logic [N-1:0]    grant_oh
);

  state_t          r_state, w_state_nxt;
  logic [IDXW-1:0] r_grant_idx, w_idx_nxt;
  logic [N-1:0]    r_grant_oh, w_oh_nxt;
  logic [IDXW-1:0] r_ptr, w_ptr_nxt;
  logic            w_accept;
  logic [IDXW-1:0] w_win_idx;
  logic            w_win_any;

  // The picker sees the post-acceptance pointer so back-to-back grants rotate.
  rr_pick #(.N(N), .IDXW(IDXW)) u_pick (
    .req     (req),
    .ptr     (w_ptr_nxt),
    .rr_en   (rr_en),
    .win_idx (w_win_idx),
    .win_any (w_win_any)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_grant_idx;
    w_oh_nxt    = r_grant_oh;
    w_ptr_nxt   = r_ptr;
    w_accept    = (r_state == BUSY) && out_ready;
    if (w_accept)
      w_ptr_nxt = (r_grant_idx == '0) ? IDXW'(N - 1) : r_grant_idx - 1'b1;
    case (r_state)
      IDLE: begin
        if (w_win_any) begin
          w_state_nxt = BUSY;
          w_idx_nxt   = w_win_idx;
          w_oh_nxt    = {{(N-1){1'b0}}, 1'b1} << w_win_idx;
        end
      end
      BUSY: begin
        if (w_accept) begin
          if (w_win_any) begin
            w_idx_nxt = w_win_idx;
            w_oh_nxt  = {{(N-1){1'b0}}, 1'b1} << w_win_idx;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_grant_idx <= '0;
      r_grant_oh  <= '0;
      r_ptr       <= IDXW'(N - 1);
    end else begin
      r_state     <= w_state_nxt;
      r_grant_idx <= w_idx_nxt;
      r_grant_oh  <= w_oh_nxt;
      r_ptr       <= w_ptr_nxt;
    end
  end

  assign out_valid = (r_state == BUSY);
  assign grant_idx = r_grant_idx;
  assign grant_oh  = r_grant_oh;

endmodule

// File: tb/tb_prio_arbiter.sv
// Scoreboard bench for prio_arbiter: N=8 and N=5 instances, directed vectors.
module tb_prio_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req_a;
  logic       rr_a, rdy_a;
  logic       vld_a;
  logic [2:0] idx_a;
  logic [7:0] oh_a;
  logic [4:0] req_b;
  logic       rr_b, rdy_b;
  logic       vld_b;
  logic [2:0] idx_b;
  logic [4:0] oh_b;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int unsigned idx;
    int unsigned oh;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  always #5 clk = ~clk;

  prio_arbiter #(.N(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .rr_en(rr_a), .out_ready(rdy_a),
    .out_valid(vld_a), .grant_idx(idx_a), .grant_oh(oh_a)
  );

  prio_arbiter #(.N(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .rr_en(rr_b), .out_ready(rdy_b),
    .out_valid(vld_b), .grant_idx(idx_b), .grant_oh(oh_b)
  );

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input int unsigned idx);
    exp_t e;
    e.idx = idx;
    e.oh  = 32'd1 << idx;
    q_a.push_back(e);
  endtask

  task automatic push_b(input int unsigned idx);
    exp_t e;
    e.idx = idx;
    e.oh  = 32'd1 << idx;
    q_b.push_back(e);
  endtask

  // Monitors: every accepted grant must match the next scoreboard entry.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && vld_a === 1'b1 && rdy_a === 1'b1) begin
      if (q_a.size() == 0) begin
        check("a_unexpected_grant", {29'd0, idx_a}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q_a.pop_front();
        check("a_grant_idx", {29'd0, idx_a}, e.idx);
        check("a_grant_oh", {24'd0, oh_a}, e.oh);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && vld_b === 1'b1 && rdy_b === 1'b1) begin
      if (q_b.size() == 0) begin
        check("b_unexpected_grant", {29'd0, idx_b}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q_b.pop_front();
        check("b_grant_idx", {29'd0, idx_b}, e.idx);
        check("b_grant_oh", {27'd0, oh_b}, e.oh);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rr_seq[9];
    rr_seq = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
    rst_n = 1'b0;
    req_a = '0; rr_a = 1'b0; rdy_a = 1'b0;
    req_b = '0; rr_b = 1'b0; rdy_b = 1'b0;
    repeat (3) tick();
    check("reset_valid", {31'd0, vld_a}, 0);
    check("reset_idx", {29'd0, idx_a}, 0);
    check("reset_oh", {24'd0, oh_a}, 0);
    rst_n = 1'b1;

    // Fixed priority: highest index of 0100_0010 is 6.
    req_a = 8'h42; rr_a = 1'b0; rdy_a = 1'b1;
    push_a(6);
    tick();
    check("fixed_valid", {31'd0, vld_a}, 1);
    req_a = 8'h00;
    tick();

    // Idle, no requests.
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_valid", {31'd0, vld_a}, 0);
    end

    // Restart from ptr=N-1 for the round-robin sweep.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req_a = 8'hFF; rr_a = 1'b1; rdy_a = 1'b1;
    for (int i = 0; i < 9; i++) push_a(rr_seq[i]);
    for (int i = 0; i < 9; i++) begin
      tick();
      check("rr_valid_continuous", {31'd0, vld_a}, 1);
    end
    req_a = 8'h00;
    tick();
    check("rr_return_idle", {31'd0, vld_a}, 0);

    // Backpressure: grant 0 held while req changes to 0x80.
    req_a = 8'h01; rr_a = 1'b0; rdy_a = 1'b0;
    push_a(0);
    push_a(7);
    tick();
    req_a = 8'h80;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_valid", {31'd0, vld_a}, 1);
      check("bp_idx", {29'd0, idx_a}, 0);
      check("bp_oh", {24'd0, oh_a}, 32'h01);
    end
    rdy_a = 1'b1;
    tick();
    req_a = 8'h00;
    tick();

    // Reset mid-grant: ptr is 6 here, so round-robin over 0xFF picks 6.
    req_a = 8'hFF; rr_a = 1'b1; rdy_a = 1'b1;
    tick();
    check("pre_reset_valid", {31'd0, vld_a}, 1);
    check("pre_reset_idx", {29'd0, idx_a}, 6);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midreset_valid", {31'd0, vld_a}, 0);
    check("midreset_idx", {29'd0, idx_a}, 0);
    check("midreset_oh", {24'd0, oh_a}, 0);
    req_a = 8'h05; rr_a = 1'b1; rdy_a = 1'b1;
    push_a(2);
    tick();
    req_a = 8'h00;
    tick();

    // N=5 wrap: 4 -> 0 -> 4 with req 10001 held.
    req_b = 5'b10001; rr_b = 1'b1; rdy_b = 1'b1;
    push_b(4);
    push_b(0);
    push_b(4);
    repeat (3) tick();
    req_b = 5'b00000;
    tick();
    tick();
    check("b_return_idle", {31'd0, vld_b}, 0);

    check("a_scoreboard_drained", q_a.size(), 0);
    check("b_scoreboard_drained", q_b.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
